// File: rtl/scanner_node.sv
// scanner_node: scanner control FSM (LOWPOWER/STANDBY/COLLECTING/IDLE/TRANSFERRING/FLUSHING).
// Optional feature macro: SCANNER_STANDBY_TIMEOUT_EN. When defined, STANDBY counts up and
// falls back to LOWPOWER after STANDBY_TIMEOUT cycles unless a scan request arrives.
//
//  state        | meaning
//  -------------+---------------------------------------------------------
//  LOWPOWER     | asleep, waiting for wake button or peer GO_TO_STANDBY
//  STANDBY      | awake, waiting for scan button or peer START_SCAN
//  COLLECTING   | timed collect phase, issues peer commands at set counts
//  IDLE         | data held, waiting for transfer button or peer START_FLUSH
//  TRANSFERRING | timed transfer phase, then back to LOWPOWER
//  FLUSHING     | timed flush phase, then back to LOWPOWER
module scanner_node #(
    parameter int CW              = 4,
    parameter int COLLECT_CYCLES  = 10,
    parameter int XFER_CYCLES     = 3,
    parameter int FLUSH_CYCLES    = 3,
    parameter int STANDBY_AT      = 7,
    parameter int START_AT        = 8,
    parameter int FLUSH_AT        = 5,
    parameter int STANDBY_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    user_input,
    input  logic [1:0]    receive_comm,
    output logic [1:0]    transmit_comm,
    output logic [2:0]    state,
    output logic [CW-1:0] count,
    output logic          phase_done
);

    localparam logic [2:0] ST_LOWPOWER   = 3'b000;
    localparam logic [2:0] ST_STANDBY    = 3'b001;
    localparam logic [2:0] ST_COLLECTING = 3'b010;
    localparam logic [2:0] ST_IDLE       = 3'b011;
    localparam logic [2:0] ST_XFER       = 3'b100;
    localparam logic [2:0] ST_FLUSHING   = 3'b101;

    localparam logic [1:0] CMD_NONE    = 2'b00;
    localparam logic [1:0] CMD_STANDBY = 2'b01;
    localparam logic [1:0] CMD_START   = 2'b10;
    localparam logic [1:0] CMD_FLUSH   = 2'b11;

    localparam logic [CW-1:0] COLLECT_LAST = CW'(COLLECT_CYCLES - 1);
    localparam logic [CW-1:0] XFER_LAST    = CW'(XFER_CYCLES - 1);
    localparam logic [CW-1:0] FLUSH_LAST   = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] STANDBY_CNT  = CW'(STANDBY_AT);
    localparam logic [CW-1:0] START_CNT    = CW'(START_AT);
    localparam logic [CW-1:0] FLUSH_CNT    = CW'(FLUSH_AT);
`ifdef SCANNER_STANDBY_TIMEOUT_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(STANDBY_TIMEOUT - 1);
`endif

    // Reject parameter sets where command points collide or fall outside the collect phase.
    if (STANDBY_AT >= COLLECT_CYCLES || START_AT >= COLLECT_CYCLES || FLUSH_AT >= COLLECT_CYCLES ||
        STANDBY_AT == START_AT || STANDBY_AT == FLUSH_AT || START_AT == FLUSH_AT ||
        COLLECT_CYCLES < 1 || XFER_CYCLES < 1 || FLUSH_CYCLES < 1 || STANDBY_TIMEOUT < 1) begin : g_bad_params
        $error("scanner_node: illegal parameter combination");
    end

    logic [2:0]    state_next;
    logic [CW-1:0] count_next;
    logic          collect_last;
    logic          xfer_last;
    logic          flush_last;
    logic          scan_req;

    // State and count registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_LOWPOWER;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state and next-count selection; any state change restarts the count.
    always_comb begin
        state_next = state;
        count_next = '0;
        scan_req   = user_input[2] || (receive_comm == CMD_START);
        case (state)
            ST_LOWPOWER: begin
                if (user_input[0] || receive_comm == CMD_STANDBY) state_next = ST_STANDBY;
            end
            ST_STANDBY: begin
`ifdef SCANNER_STANDBY_TIMEOUT_EN
                if (scan_req)                    state_next = ST_COLLECTING;
                else if (count == TIMEOUT_LAST)  state_next = ST_LOWPOWER;
                else                             count_next = count + CW'(1);
`else
                if (scan_req) state_next = ST_COLLECTING;
`endif
            end
            ST_COLLECTING: begin
                if (collect_last) state_next = ST_IDLE;
                else              count_next = count + CW'(1);
            end
            ST_IDLE: begin
                if (user_input[1])                  state_next = ST_XFER;
                else if (receive_comm == CMD_FLUSH) state_next = ST_FLUSHING;
            end
            ST_XFER: begin
                if (xfer_last) state_next = ST_LOWPOWER;
                else           count_next = count + CW'(1);
            end
            ST_FLUSHING: begin
                if (flush_last) state_next = ST_LOWPOWER;
                else            count_next = count + CW'(1);
            end
            default: state_next = ST_LOWPOWER;
        endcase
        if (state_next != state) count_next = '0;
    end

    // Moore outputs decoded from the registered state and count only.
    always_comb begin
        collect_last  = (state == ST_COLLECTING) && (count == COLLECT_LAST);
        xfer_last     = (state == ST_XFER)       && (count == XFER_LAST);
        flush_last    = (state == ST_FLUSHING)   && (count == FLUSH_LAST);
        phase_done    = collect_last || xfer_last || flush_last;
        transmit_comm = CMD_NONE;
        if (state == ST_COLLECTING) begin
            if (count == STANDBY_CNT)    transmit_comm = CMD_STANDBY;
            else if (count == START_CNT) transmit_comm = CMD_START;
            else if (count == FLUSH_CNT) transmit_comm = CMD_FLUSH;
        end
    end

endmodule

// File: tb/tb_scanner_node.sv
// Self-checking bench for scanner_node: directed walk through the scanner phases,
// an asynchronous reset mid-collect, the STANDBY dwell behaviour, then random stimulus.
// Expected outputs are queued by the driver and compared by a negedge monitor.
module tb_scanner_node;

    localparam int CW = 4;
    localparam int COLLECT_CYCLES = 10, XFER_CYCLES = 3, FLUSH_CYCLES = 3;
    localparam int STANDBY_AT = 7, START_AT = 8, FLUSH_AT = 5, STANDBY_TIMEOUT = 16;

    localparam int LP = 0, SB = 1, COLL = 2, IDLE = 3, XFER = 4, FLUSH = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    user_input;
    logic [1:0]    receive_comm;
    logic [1:0]    transmit_comm;
    logic [2:0]    state;
    logic [CW-1:0] count;
    logic          phase_done;

    scanner_node #(
        .CW(CW), .COLLECT_CYCLES(COLLECT_CYCLES), .XFER_CYCLES(XFER_CYCLES),
        .FLUSH_CYCLES(FLUSH_CYCLES), .STANDBY_AT(STANDBY_AT), .START_AT(START_AT),
        .FLUSH_AT(FLUSH_AT), .STANDBY_TIMEOUT(STANDBY_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .user_input(user_input), .receive_comm(receive_comm),
        .transmit_comm(transmit_comm), .state(state), .count(count), .phase_done(phase_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int cnt;
        int tx;
        int pd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: phase name and time spent in it.
    int m_st  = LP;
    int m_cnt = 0;

    function automatic void chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endfunction

    function automatic int phase_len(input int st);
        case (st)
            COLL:    return COLLECT_CYCLES;
            XFER:    return XFER_CYCLES;
            FLUSH:   return FLUSH_CYCLES;
            default: return 0;
        endcase
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        e.st  = m_st;
        e.cnt = m_cnt;
        e.tx  = 0;
        if (m_st == COLL) begin
            if (m_cnt == STANDBY_AT)    e.tx = 1;
            else if (m_cnt == START_AT) e.tx = 2;
            else if (m_cnt == FLUSH_AT) e.tx = 3;
        end
        e.pd = (phase_len(m_st) != 0 && m_cnt == phase_len(m_st) - 1) ? 1 : 0;
        return e;
    endfunction

    function automatic void enter(input int st);
        m_st  = st;
        m_cnt = 0;
    endfunction

    function automatic void model_advance(input logic [2:0] ui, input logic [1:0] rc);
        case (m_st)
            LP:   if (ui[0] || rc == 2'b01) enter(SB);
            SB: begin
                if (ui[2] || rc == 2'b10) enter(COLL);
`ifdef SCANNER_STANDBY_TIMEOUT_EN
                else if (m_cnt == STANDBY_TIMEOUT - 1) enter(LP);
                else m_cnt++;
`endif
            end
            IDLE: begin
                if (ui[1])             enter(XFER);
                else if (rc == 2'b11)  enter(FLUSH);
            end
            COLL, XFER, FLUSH: begin
                if (m_cnt == phase_len(m_st) - 1) enter(m_st == COLL ? IDLE : LP);
                else m_cnt++;
            end
            default: enter(LP);
        endcase
    endfunction

    // One clock: queue expected outputs for this cycle, apply inputs, advance the model.
    task automatic step(input logic [2:0] ui, input logic [1:0] rc);
        exp_q.push_back(model_outputs());
        user_input   = ui;
        receive_comm = rc;
        model_advance(ui, rc);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mon_state", int'(state), e.st);
                chk("mon_count", int'(count), e.cnt);
                chk("mon_transmit_comm", int'(transmit_comm), e.tx);
                chk("mon_phase_done", int'(phase_done), e.pd);
            end
        end
    end

    initial begin
        reset        = 1'b0;
        user_input   = 3'b000;
        receive_comm = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", int'(state), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_tx", int'(transmit_comm), 0);
        chk("reset_phase_done", int'(phase_done), 0);
        reset = 1'b1;
        enter(LP);

        // Wake, then scan from peer.
        step(3'b001, 2'b00);
        chk("wake_state", int'(state), 1);
        chk("wake_count", int'(count), 0);
        chk("wake_tx", int'(transmit_comm), 0);
        step(3'b000, 2'b10);
        chk("scan_state", int'(state), 2);
        for (int i = 0; i < 10; i++) begin
            chk("collect_count", int'(count), i);
            chk("collect_tx", int'(transmit_comm), (i == 5) ? 3 : (i == 7) ? 1 : (i == 8) ? 2 : 0);
            chk("collect_phase_done", int'(phase_done), (i == 9) ? 1 : 0);
            step(3'b000, 2'b00);
        end
        chk("after_collect_state", int'(state), 3);

        // Transfer beats flush when both arrive together.
        step(3'b010, 2'b11);
        chk("xfer_priority_state", int'(state), 4);
        for (int i = 0; i < 3; i++) begin
            chk("xfer_phase_done", int'(phase_done), (i == 2) ? 1 : 0);
            step(3'b000, 2'b00);
        end
        chk("after_xfer_state", int'(state), 0);

        // Flush path.
        step(3'b001, 2'b00);
        step(3'b100, 2'b00);
        repeat (10) step(3'b000, 2'b00);
        step(3'b000, 2'b11);
        chk("flush_state", int'(state), 5);
        for (int i = 0; i < 3; i++) begin
            chk("flush_count", int'(count), i);
            chk("flush_phase_done", int'(phase_done), (i == 2) ? 1 : 0);
            step(3'b000, 2'b00);
        end
        chk("after_flush_state", int'(state), 0);

        // Asynchronous reset mid-collect, between edges.
        step(3'b001, 2'b00);
        step(3'b000, 2'b10);
        repeat (4) step(3'b000, 2'b00);
        chk("pre_reset_count", int'(count), 4);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_state", int'(state), 0);
        chk("async_reset_count", int'(count), 0);
        chk("async_reset_tx", int'(transmit_comm), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        enter(LP);

        // STANDBY dwell with no stimulus.
        step(3'b001, 2'b00);
`ifdef SCANNER_STANDBY_TIMEOUT_EN
        repeat (15) step(3'b000, 2'b00);
        chk("standby_count15_state", int'(state), 1);
        chk("standby_count15", int'(count), 15);
        step(3'b000, 2'b00);
        chk("standby_timeout_state", int'(state), 0);
        step(3'b001, 2'b00);
        repeat (15) step(3'b000, 2'b00);
        step(3'b100, 2'b00);
        chk("standby_scan_wins_state", int'(state), 2);
`else
        repeat (100) step(3'b000, 2'b00);
        chk("standby_hold_state", int'(state), 1);
        chk("standby_hold_count", int'(count), 0);
`endif

        // Random stimulus: sparse button presses, peer commands half the time.
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] ui;
            logic [1:0] rc;
            for (int b = 0; b < 3; b++) ui[b] = ($urandom_range(0, 3) == 0);
            rc = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            step(ui, rc);
        end

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
